step_sequencer: RTL and testbench

Synthesizable stimulus controller for the 4-bit combinational unit under test: it drives the unit's A input through a programmed list of (value, hold) steps and captures the unit's B output at the end of each step. It replaces hand-timed `#delay` stimulus with a cycle-exact, reusable schedule. It sits between a configuration master, which loads the step table and starts runs, and the datapath instance, which it owns exclusively while busy.

---
 rtl/step_seq_pkg.sv | 16 +
 rtl/step_sequencer_if.sv | 34 +++
 rtl/step_table.sv | 36 +++
 rtl/step_sequencer.sv | 138 +++++++++++++
 tb/tb_step_sequencer.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/step_seq_pkg.sv
// Shared types, default parameters and helpers for the step sequencer.
package step_seq_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam int DEF_DATA_W   = 4;
    localparam int DEF_HOLD_W   = 8;
    localparam int DEF_DEPTH    = 4;
    localparam int DEF_IDLE_VAL = 0;

    // Requested run length saturates at the table depth.
    function automatic int clamp_len(input int len, input int depth);
        return (len > depth) ? depth : len;
    endfunction

endpackage

// File: rtl/step_sequencer_if.sv
// Control-side bus between the configuration master and the step sequencer.
interface step_sequencer_if
    import step_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int HOLD_W = DEF_HOLD_W,
    parameter int DEPTH  = DEF_DEPTH
);
    localparam int AW = $clog2(DEPTH);

    logic              cfg_we;
    logic [AW-1:0]     cfg_addr;
    logic [DATA_W-1:0] cfg_value;
    logic [HOLD_W-1:0] cfg_hold;
    logic              start;
    logic [AW:0]       len;
    logic              abort;
    logic              busy;
    logic              done;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic [AW-1:0]     res_idx;

    modport master (
        output cfg_we, cfg_addr, cfg_value, cfg_hold, start, len, abort,
        input  busy, done, res_valid, res_data, res_idx
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_value, cfg_hold, start, len, abort,
        output busy, done, res_valid, res_data, res_idx
    );

endinterface

// File: rtl/step_table.sv
// Step table: DEPTH x (value, hold) registers, one write port usable only
// while idle, one combinational read port.
module step_table #(
    parameter int DATA_W = 4,
    parameter int HOLD_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       idle,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [DATA_W-1:0]          wvalue,
    input  logic [HOLD_W-1:0]          whold,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [DATA_W-1:0]          rvalue,
    output logic [HOLD_W-1:0]          rhold
);
    logic [DEPTH-1:0][DATA_W-1:0] value_q;
    logic [DEPTH-1:0][HOLD_W-1:0] hold_q;

    // The table is frozen outside IDLE so a run always sees a stable schedule.
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
            hold_q  <= '0;
        end else if (we && idle) begin
            value_q[waddr] <= wvalue;
            hold_q[waddr]  <= whold;
        end
    end

    assign rvalue = value_q[raddr];
    assign rhold  = hold_q[raddr];

endmodule

// File: rtl/step_sequencer.sv
// Drives the datapath A input through the programmed (value, hold) steps and
// captures B at the end of each step.
module step_sequencer
    import step_seq_pkg::*;
#(
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                HOLD_W   = DEF_HOLD_W,
    parameter int                DEPTH    = DEF_DEPTH,
    parameter logic [DATA_W-1:0] IDLE_VAL = DATA_W'(DEF_IDLE_VAL)
) (
    input  logic              clk,
    input  logic              rst,
    step_sequencer_if.slave   ctl,
    output logic [DATA_W-1:0] dut_a,
    input  logic [DATA_W-1:0] dut_b
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    state_t            state;
    logic [AW-1:0]     idx;
    logic [AW-1:0]     nxt_idx;
    logic [LW-1:0]     len_q;
    logic [LW-1:0]     len_eff;
    logic [HOLD_W-1:0] hold_cnt;
    logic [DATA_W-1:0] rd_value;
    logic [HOLD_W-1:0] rd_hold;
    logic [DATA_W-1:0] first_value;
    logic [HOLD_W-1:0] first_hold;
    logic              idle;
    logic              fwd0;
    logic              step_end;
    logic              last_step;
    logic              busy_q;
    logic              done_q;
    logic              res_valid_q;
    logic [DATA_W-1:0] res_data_q;
    logic [AW-1:0]     res_idx_q;

    assign idle = (state == IDLE);

    // The read port looks one step ahead so dut_a can be registered at the
    // step boundary; in IDLE it points at entry 0 for the first step.
    assign nxt_idx = (state == RUN) ? idx + AW'(1) : '0;

    step_table #(
        .DATA_W (DATA_W),
        .HOLD_W (HOLD_W),
        .DEPTH  (DEPTH)
    ) u_table (
        .clk    (clk),
        .rst    (rst),
        .idle   (idle),
        .we     (ctl.cfg_we),
        .waddr  (ctl.cfg_addr),
        .wvalue (ctl.cfg_value),
        .whold  (ctl.cfg_hold),
        .raddr  (nxt_idx),
        .rvalue (rd_value),
        .rhold  (rd_hold)
    );

    // A write to entry 0 in the start cycle must already be seen by step 0.
    assign fwd0        = ctl.cfg_we && (ctl.cfg_addr == '0);
    assign first_value = fwd0 ? ctl.cfg_value : rd_value;
    assign first_hold  = fwd0 ? ctl.cfg_hold  : rd_hold;

    assign len_eff   = LW'(clamp_len(int'(ctl.len), DEPTH));
    assign step_end  = (hold_cnt == '0);
    assign last_step = ({1'b0, idx} == len_q - LW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            len_q       <= '0;
            hold_cnt    <= '0;
            dut_a       <= IDLE_VAL;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_idx_q   <= '0;
        end else begin
            done_q      <= 1'b0;
            res_valid_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (ctl.start) begin
                        len_q <= len_eff;
                        idx   <= '0;
                        if (len_eff == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state    <= RUN;
                            busy_q   <= 1'b1;
                            dut_a    <= first_value;
                            hold_cnt <= first_hold;
                        end
                    end
                end
                RUN: begin
                    if (ctl.abort) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        dut_a  <= IDLE_VAL;
                    end else if (step_end) begin
                        res_valid_q <= 1'b1;
                        res_data_q  <= dut_b;
                        res_idx_q   <= idx;
                        if (last_step) begin
                            state  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            dut_a  <= IDLE_VAL;
                        end else begin
                            idx      <= nxt_idx;
                            dut_a    <= rd_value;
                            hold_cnt <= rd_hold;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign ctl.busy      = busy_q;
    assign ctl.done      = done_q;
    assign ctl.res_valid = res_valid_q;
    assign ctl.res_data  = res_data_q;
    assign ctl.res_idx   = res_idx_q;

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: directed and randomized runs checked cycle by
// cycle against a schedule built from the table contents.
module tb_step_sequencer;

    localparam logic [3:0] IDLE_V = 4'h6;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] dut_a;
    logic [3:0] dut_b;

    step_sequencer_if #(.DATA_W(4), .HOLD_W(8), .DEPTH(4)) ctl ();

    step_sequencer #(
        .DATA_W   (4),
        .HOLD_W   (8),
        .DEPTH    (4),
        .IDLE_VAL (IDLE_V)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .ctl   (ctl),
        .dut_a (dut_a),
        .dut_b (dut_b)
    );

    // Unit under test modelled as B = ~A.
    assign dut_b = ~dut_a;

    always #5 clk = ~clk;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [3:0] m_val  [4];
    logic [7:0] m_hold [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " dut_a"},     32'(dut_a),         32'(IDLE_V));
        chk({tag, " busy"},      32'(ctl.busy),      32'(0));
        chk({tag, " done"},      32'(ctl.done),      32'(0));
        chk({tag, " res_valid"}, 32'(ctl.res_valid), 32'(0));
        chk({tag, " res_data"},  32'(ctl.res_data),  32'(0));
        chk({tag, " res_idx"},   32'(ctl.res_idx),   32'(0));
    endtask

    // Called at a negedge while idle; the write lands on the next posedge.
    task automatic cfg_write(input int a, input logic [3:0] v, input logic [7:0] h);
        ctl.cfg_we    = 1'b1;
        ctl.cfg_addr  = 2'(a);
        ctl.cfg_value = v;
        ctl.cfg_hold  = h;
        @(negedge clk);
        ctl.cfg_we = 1'b0;
        m_val[a]  = v;
        m_hold[a] = h;
    endtask

    // Starts a run from a negedge in IDLE and checks every following cycle.
    // abort_c: cycle in which abort is raised (0 = none); mid_c: cycle in which
    // a stray start and a write to entry 1 are raised; wr0: write entry 0 in
    // the start cycle; poke_done: raise start while DONE.
    task automatic run(input int l, input int abort_c, input int mid_c,
                       input bit wr0, input bit poke_done);
        int         eff, n, last, ek;
        int         rv_at [4];
        logic [3:0] seq [$];
        logic [3:0] exp_a, exp_d;
        bit         live, exp_rv;
        ctl.start = 1'b1;
        ctl.len   = 3'(l);
        if (wr0) begin
            ctl.cfg_we    = 1'b1;
            ctl.cfg_addr  = 2'd0;
            ctl.cfg_value = 4'($urandom);
            ctl.cfg_hold  = 8'($urandom_range(0, 4));
            m_val[0]  = ctl.cfg_value;
            m_hold[0] = ctl.cfg_hold;
        end
        eff = (l > 4) ? 4 : l;
        n   = 0;
        for (int k = 0; k < eff; k++) begin
            for (int j = 0; j <= int'(m_hold[k]); j++) seq.push_back(m_val[k]);
            n += int'(m_hold[k]) + 1;
            rv_at[k] = n + 1;
        end
        last = (abort_c > 0) ? abort_c + 1 : n + 2;
        @(posedge clk);
        #1;
        ctl.start  = 1'b0;
        ctl.cfg_we = 1'b0;
        ctl.len    = 3'($urandom);
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            live   = (abort_c == 0) || (c <= abort_c);
            exp_rv = 1'b0;
            ek     = 0;
            for (int k = 0; k < eff; k++)
                if (live && rv_at[k] == c) begin
                    exp_rv = 1'b1;
                    ek     = k;
                end
            exp_a = IDLE_V;
            if (live && c <= n) exp_a = seq[c-1];
            chk($sformatf("busy c%0d", c),      32'(ctl.busy),      32'(live && c <= n));
            chk($sformatf("done c%0d", c),      32'(ctl.done),      32'(live && c == n + 1));
            chk($sformatf("dut_a c%0d", c),     32'(dut_a),         32'(exp_a));
            chk($sformatf("res_valid c%0d", c), 32'(ctl.res_valid), 32'(exp_rv));
            if (exp_rv) begin
                exp_d = ~m_val[ek];
                chk($sformatf("res_data c%0d", c), 32'(ctl.res_data), 32'(exp_d));
                chk($sformatf("res_idx c%0d", c),  32'(ctl.res_idx),  32'(ek));
            end
            if (c == abort_c)     ctl.abort = 1'b1;
            if (c == abort_c + 1) ctl.abort = 1'b0;
            if (c == mid_c) begin
                ctl.start     = 1'b1;
                ctl.len       = 3'($urandom);
                ctl.cfg_we    = 1'b1;
                ctl.cfg_addr  = 2'd1;
                ctl.cfg_value = ~m_val[1];
                ctl.cfg_hold  = m_hold[1] + 8'd3;
            end
            if (c == mid_c + 1) begin
                ctl.start  = 1'b0;
                ctl.cfg_we = 1'b0;
            end
            if (poke_done && c == n + 1) begin
                ctl.start = 1'b1;
                ctl.len   = 3'd1;
            end
            if (poke_done && c == n + 2) ctl.start = 1'b0;
        end
    endtask

    initial begin
        rst           = 1'b1;
        ctl.cfg_we    = 1'b0;
        ctl.cfg_addr  = '0;
        ctl.cfg_value = '0;
        ctl.cfg_hold  = '0;
        ctl.start     = 1'b0;
        ctl.len       = '0;
        ctl.abort     = 1'b0;
        for (int k = 0; k < 4; k++) begin
            m_val[k]  = '0;
            m_hold[k] = '0;
        end
        repeat (2) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;
        @(negedge clk);

        // Reference schedule: 50 + 100 + 100 cycles.
        cfg_write(0, 4'b1010, 8'd49);
        cfg_write(1, 4'b1100, 8'd99);
        cfg_write(2, 4'b0000, 8'd99);
        run(3, 0, 0, 1'b0, 1'b0);

        run(0, 0, 0, 1'b0, 1'b0);

        // Over-long length clamps to the table depth; start during DONE is ignored.
        cfg_write(3, 4'h9, 8'd2);
        run(7, 0, 0, 1'b0, 1'b1);

        repeat (6) begin
            for (int k = 0; k < 4; k++)
                cfg_write(k, 4'($urandom), 8'($urandom_range(0, 6)));
            run(int'($urandom_range(0, 7)), 0, 0, 1'b0, 1'b0);
        end

        // Stray start and table write mid-run, then re-run on the old table.
        for (int k = 0; k < 4; k++)
            cfg_write(k, 4'($urandom), 8'($urandom_range(1, 4)));
        run(4, 0, 3, 1'b0, 1'b0);
        run(4, 0, 0, 1'b0, 1'b0);

        // Abort inside step 1, then an immediate restart.
        run(3, int'(m_hold[0]) + 2 + int'($urandom_range(0, int'(m_hold[1]))), 0, 1'b0, 1'b0);
        run(2, 0, 0, 1'b0, 1'b0);
        // Abort on step 1's last cycle drops its capture.
        run(3, int'(m_hold[0]) + int'(m_hold[1]) + 2, 0, 1'b0, 1'b0);

        run(2, 0, 0, 1'b1, 1'b0);

        cfg_write(0, 4'h3, 8'hFF);
        run(1, 0, 0, 1'b0, 1'b0);

        cfg_write(0, 4'h1, 8'd0);
        cfg_write(1, 4'h2, 8'd0);
        cfg_write(2, 4'h4, 8'd0);
        cfg_write(3, 4'h8, 8'd0);
        run(4, 0, 0, 1'b0, 1'b0);

        // Reset in the middle of a run clears outputs and the table.
        ctl.start = 1'b1;
        ctl.len   = 3'd4;
        @(posedge clk);
        #1;
        ctl.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset("midrun reset");
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            m_val[k]  = '0;
            m_hold[k] = '0;
        end
        run(4, 0, 0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
